// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid bit, control bundle and data payload.
// Supports flush, stall and bubble, and keeps saturating counters for each event.
module pipe_stage_reg #(
    parameter int CTRL_W   = 8,
    parameter int DATA_W   = 96,
    parameter int CNT_W    = 16,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              cnt_clr_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stall_evt;
    logic flush_evt;
    logic bubble_evt;

    // Event qualification follows the flush > stall > bubble priority.
    assign stall_evt  = stall_i & ~flush_i;
    assign flush_evt  = flush_i & valid_o;
    assign bubble_evt = bubble_i & ~flush_i & ~stall_i;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= '0;
            data_o  <= '0;
        end else if (flush_i || (bubble_i && !stall_i)) begin
            valid_o <= 1'b0;
            ctrl_o  <= '0;
            if (CLR_DATA) begin
                data_o <= '0;
            end
        end else if (!stall_i) begin
            // ctrl is gated by valid_i so an unused bundle never leaks out.
            valid_o <= valid_i;
            ctrl_o  <= valid_i ? ctrl_i : '0;
            data_o  <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_o  <= '0;
            flush_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o  <= '0;
            flush_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_evt && stall_cnt_o != CNT_MAX) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (flush_evt && flush_cnt_o != CNT_MAX) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
            if (bubble_evt && bubble_cnt_o != CNT_MAX) begin
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a 4-bit-counter instance
// that holds data on squash, and a default-width instance that clears it.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 96;

    logic              clk_i = 1'b0;
    logic              start_i;
    logic              stall_i, flush_i, bubble_i, valid_i, cnt_clr_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;

    logic              valid_o, valid_c;
    logic [CTRL_W-1:0] ctrl_o, ctrl_c;
    logic [DATA_W-1:0] data_o, data_c;
    logic [3:0]        stall_cnt_o, flush_cnt_o, bubble_cnt_o;
    logic [15:0]       stall_cnt_c, flush_cnt_c, bubble_cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4), .CLR_DATA(1'b0)) dut (
        .clk_i(clk_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
        .bubble_i(bubble_i), .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .cnt_clr_i(cnt_clr_i), .valid_o(valid_o), .ctrl_o(ctrl_o), .data_o(data_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16), .CLR_DATA(1'b1)) dut_clr (
        .clk_i(clk_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
        .bubble_i(bubble_i), .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .cnt_clr_i(cnt_clr_i), .valid_o(valid_c), .ctrl_o(ctrl_c), .data_o(data_c),
        .stall_cnt_o(stall_cnt_c), .flush_cnt_o(flush_cnt_c), .bubble_cnt_o(bubble_cnt_c)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid"}, 128'(valid_o), 128'(0));
        checkOutput({tag, " ctrl"}, 128'(ctrl_o), 128'(0));
        checkOutput({tag, " data"}, 128'(data_o), 128'(0));
        checkOutput({tag, " stall_cnt"}, 128'(stall_cnt_o), 128'(0));
        checkOutput({tag, " flush_cnt"}, 128'(flush_cnt_o), 128'(0));
        checkOutput({tag, " bubble_cnt"}, 128'(bubble_cnt_o), 128'(0));
        checkOutput({tag, " clr valid"}, 128'(valid_c), 128'(0));
        checkOutput({tag, " clr data"}, 128'(data_c), 128'(0));
    endtask

    initial begin
        start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
        valid_i = 1'b0; cnt_clr_i = 1'b0; ctrl_i = '0; data_i = '0;
        #1 start_i = 1'b0;

        // Reset held for two edges, then first load
        valid_i = 1'b1; ctrl_i = 8'hA5; data_i = 96'h1234;
        applyStimulus(2);
        checkAllZero("reset");
        start_i = 1'b1;
        applyStimulus(1);
        checkOutput("load valid", 128'(valid_o), 128'(1));
        checkOutput("load ctrl", 128'(ctrl_o), 128'(8'hA5));
        checkOutput("load data", 128'(data_o), 128'(96'h1234));

        // Stall three cycles, then release
        stall_i = 1'b1; ctrl_i = 8'h3C; data_i = 96'h5678;
        applyStimulus(3);
        checkOutput("stall ctrl", 128'(ctrl_o), 128'(8'hA5));
        checkOutput("stall data", 128'(data_o), 128'(96'h1234));
        checkOutput("stall cnt", 128'(stall_cnt_o), 128'(3));
        stall_i = 1'b0;
        applyStimulus(1);
        checkOutput("release ctrl", 128'(ctrl_o), 128'(8'h3C));
        checkOutput("release data", 128'(data_o), 128'(96'h5678));

        // Flush beats stall; second flush on an empty stage is not counted
        flush_i = 1'b1; stall_i = 1'b1;
        applyStimulus(1);
        checkOutput("flush valid", 128'(valid_o), 128'(0));
        checkOutput("flush ctrl", 128'(ctrl_o), 128'(0));
        checkOutput("flush data hold", 128'(data_o), 128'(96'h5678));
        checkOutput("flush data clr", 128'(data_c), 128'(0));
        checkOutput("flush cnt", 128'(flush_cnt_o), 128'(1));
        checkOutput("flush stall cnt", 128'(stall_cnt_o), 128'(3));
        stall_i = 1'b0;
        applyStimulus(1);
        checkOutput("flush empty cnt", 128'(flush_cnt_o), 128'(1));

        // Bubble then reload
        flush_i = 1'b0; bubble_i = 1'b1; valid_i = 1'b1; ctrl_i = 8'hFF; data_i = 96'h9ABC;
        applyStimulus(1);
        checkOutput("bubble valid", 128'(valid_o), 128'(0));
        checkOutput("bubble ctrl", 128'(ctrl_o), 128'(0));
        checkOutput("bubble data hold", 128'(data_o), 128'(96'h5678));
        checkOutput("bubble data clr", 128'(data_c), 128'(0));
        checkOutput("bubble cnt", 128'(bubble_cnt_o), 128'(1));
        bubble_i = 1'b0;
        applyStimulus(1);
        checkOutput("reload valid", 128'(valid_o), 128'(1));
        checkOutput("reload ctrl", 128'(ctrl_o), 128'(8'hFF));
        checkOutput("reload data", 128'(data_o), 128'(96'h9ABC));

        // Saturation of the 4-bit counter, then clear overriding increment
        stall_i = 1'b1;
        applyStimulus(20);
        checkOutput("sat stall cnt", 128'(stall_cnt_o), 128'(15));
        checkOutput("wide stall cnt", 128'(stall_cnt_c), 128'(23));
        cnt_clr_i = 1'b1;
        applyStimulus(1);
        checkOutput("clr stall cnt", 128'(stall_cnt_o), 128'(0));
        checkOutput("clr flush cnt", 128'(flush_cnt_o), 128'(0));
        checkOutput("clr bubble cnt", 128'(bubble_cnt_o), 128'(0));
        checkOutput("clr wide stall", 128'(stall_cnt_c), 128'(0));
        cnt_clr_i = 1'b0; bubble_i = 1'b1;
        applyStimulus(1);
        checkOutput("stall+bubble stall cnt", 128'(stall_cnt_o), 128'(1));
        checkOutput("stall+bubble bubble cnt", 128'(bubble_cnt_o), 128'(0));
        checkOutput("stall+bubble valid", 128'(valid_o), 128'(1));
        stall_i = 1'b0; bubble_i = 1'b0;

        // Asynchronous reset between edges
        valid_i = 1'b1; ctrl_i = 8'h5A; data_i = 96'h1111;
        applyStimulus(1);
        checkOutput("pre-reset ctrl", 128'(ctrl_o), 128'(8'h5A));
        #2 start_i = 1'b0;
        #1;
        checkAllZero("async reset");
        start_i = 1'b1;
        valid_i = 1'b0; ctrl_i = 8'hFF; data_i = 96'h2222;
        applyStimulus(1);
        checkOutput("invalid load valid", 128'(valid_o), 128'(0));
        checkOutput("invalid load ctrl", 128'(ctrl_o), 128'(0));
        checkOutput("invalid load data", 128'(data_o), 128'(96'h2222));

        // Unknown payload on an invalid load must not reach ctrl/valid
        ctrl_i = 'x; data_i = 'x;
        applyStimulus(1);
        checkOutput("xsafe valid", 128'(valid_o), 128'(0));
        checkOutput("xsafe ctrl", 128'(ctrl_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the 5-stage RISC-V core. It carries a control bundle, a data payload and a valid bit. It supports stall (hold), flush (squash), bubble insertion for load-use hazards, and saturating performance counters for stall, flush and bubble events.

Parameters:
CTRL_W, 8, width of control bundle (RegWrite/MemtoReg/MemRead/MemWrite/ALUSrc/ALUOp...); forced to 0 on squash
DATA_W, 96, width of data payload (operands, immediate, funct, register addresses)
CNT_W, 16, width of each performance counter
CLR_DATA, 0, 1 = data_o also cleared to 0 on flush/bubble; 0 = data_o holds

Ports:
clk_i  in  1  clock, rising edge
start_i  in  1  reset, asynchronous, active-low
stall_i  in  1  hold stage contents this cycle
flush_i  in  1  squash stage contents (branch mispredict/taken)
bubble_i  in  1  insert NOP at output, upstream holds (load-use)
valid_i  in  1  upstream stage holds a real instruction
ctrl_i  in  CTRL_W  control bundle from upstream
data_i  in  DATA_W  data payload from upstream
cnt_clr_i  in  1  synchronous clear of all counters
valid_o  out  1  stage holds a real instruction
ctrl_o  out  CTRL_W  registered control bundle
data_o  out  DATA_W  registered data payload
stall_cnt_o  out  CNT_W  cycles in which stall was applied
flush_cnt_o  out  CNT_W  flush events that squashed a valid instruction
bubble_cnt_o  out  CNT_W  bubbles inserted

Behaviour:
- Reset (start_i=0, asynchronous, any time including mid-stall): valid_o=0, ctrl_o=0, data_o=0, all counters=0. Held while start_i=0. The first load occurs on the first rising edge with start_i=1.
- Per rising edge, mutually exclusive actions are applied in priority order flush > stall > bubble > load:
  - Flush (flush_i=1): valid_o<=0, ctrl_o<=0. data_o<=0 if CLR_DATA=1, else data_o holds. flush_cnt_o increments only if valid_o was 1 before the edge.
  - Stall (stall_i=1, flush_i=0): all outputs hold. stall_cnt_o increments.
  - Bubble (bubble_i=1, flush_i=0, stall_i=0): valid_o<=0, ctrl_o<=0. data_o follows the CLR_DATA rule. bubble_cnt_o increments. The upstream hold is the hazard unit's job, not this block's.
  - Load (no control asserted): valid_o<=valid_i. ctrl_o<=ctrl_i if valid_i=1, else 0. data_o<=data_i unconditionally.
- Latency: 1 cycle from inputs to outputs on load. Zero combinational paths from inputs to outputs.
- Invariant: valid_o=0 implies ctrl_o=0 in every cycle after reset.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr_i=1 zeroes all three counters on the edge and overrides any same-edge increment.
  - Counter updates are independent of which datapath action occurs, apart from the increment conditions above.
- Simultaneous controls:
  - flush+stall: flush wins; stall_cnt_o does not increment.
  - stall+bubble: stall wins; bubble_cnt_o does not increment.
  - flush+bubble: flush wins.
- X-safety: with start_i=1, an X on an unselected data_i must not propagate into ctrl_o or valid_o when valid_i=0.

Test Plan:
1. Reset then load: start_i=0 for 2 cycles, then start_i=1 with valid_i=1, ctrl_i=8'hA5, data_i=96'h1234 -> outputs all 0 during reset; one edge later valid_o=1, ctrl_o=8'hA5, data_o=96'h1234.
2. Stall hold: after scenario 1, stall_i=1 for 3 cycles with ctrl_i=8'h3C -> ctrl_o stays 8'hA5; stall_cnt_o=3. Release -> ctrl_o=8'h3C next edge.
3. Flush priority: valid_o=1, then assert flush_i=1 and stall_i=1 on the same edge -> valid_o=0, ctrl_o=0; with CLR_DATA=0, data_o unchanged; flush_cnt_o=1, stall_cnt_o unchanged. A second flush with valid_o=0 leaves flush_cnt_o=1.
4. Bubble: bubble_i=1 for 1 cycle with valid_i=1, ctrl_i=8'hFF -> valid_o=0, ctrl_o=0, bubble_cnt_o=1. Next load -> valid_o=1, ctrl_o=8'hFF.
5. Counter saturation and clear: CNT_W=4, hold stall_i=1 for 20 cycles -> stall_cnt_o=15. Then cnt_clr_i=1 with stall_i=1 -> stall_cnt_o=0.
6. Asynchronous reset mid-operation: drop start_i between clock edges while valid_o=1, ctrl_o=8'h5A -> all outputs and counters 0 immediately, without waiting for a clock edge. Invalid load (valid_i=0, ctrl_i=8'hFF) -> ctrl_o=0.
